// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the register bank and the write-back stage.
// Both sides import this package so that they agree on widths and the bundle layout.
package reg_bank_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    function automatic int addr_width(input int nregs);
        return $clog2(nregs);
    endfunction

    localparam int AW_DEF = addr_width(NREGS_DEF);

    // Write-back bundle as produced by the write-back stage
    typedef struct packed {
        logic                en;
        logic [AW_DEF-1:0]   addr;
        logic [XLEN_DEF-1:0] data;
    } wb_t;

endpackage

// File: rtl/reg_bank_sb_if.sv
// Bus between the pipeline (master) and the register bank with scoreboard (slave).
// It carries the read ports, the write-back, the issue and flush controls, and the stall output.
interface reg_bank_sb_if
    import reg_bank_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2
);
    localparam int AW = addr_width(NREGS);

    logic [NRD-1:0][AW-1:0]   i_rd_addr;
    logic [NRD-1:0][XLEN-1:0] o_rd_data;
    logic [NRD-1:0]           o_rd_busy;
    logic                     i_wr_en;
    logic [AW-1:0]            i_wr_addr;
    logic [XLEN-1:0]          i_wr_data;
    logic                     i_iss_en;
    logic [AW-1:0]            i_iss_addr;
    logic                     i_flush;
    logic                     o_stall;

    modport master (
        output i_rd_addr, i_wr_en, i_wr_addr, i_wr_data, i_iss_en, i_iss_addr, i_flush,
        input  o_rd_data, o_rd_busy, o_stall
    );

    modport slave (
        input  i_rd_addr, i_wr_en, i_wr_addr, i_wr_data, i_iss_en, i_iss_addr, i_flush,
        output o_rd_data, o_rd_busy, o_stall
    );

endinterface

// File: rtl/reg_bank_sb_read_port.sv
// One combinational read port: register mux, optional write forwarding, and the busy mask.
// A forwarded write satisfies the pending mark, so the busy flag is hidden on a bypass hit.
module rb_read_port #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    parameter int AW     = 5
) (
    input  logic [AW-1:0]              rd_addr_i,
    input  logic [NREGS-1:0][XLEN-1:0] regs_i,
    input  logic [NREGS-1:0]           busy_i,
    input  logic                       wr_en_i,
    input  logic [AW-1:0]              wr_addr_i,
    input  logic [XLEN-1:0]            wr_data_i,
    output logic [XLEN-1:0]            rd_data_o,
    output logic                       rd_busy_o
);

    logic is_zero;
    logic hit;

    assign is_zero = (rd_addr_i == '0);
    assign hit     = (BYPASS != 0) && wr_en_i && (wr_addr_i == rd_addr_i) && !is_zero;

    always_comb begin
        rd_data_o = regs_i[rd_addr_i];
        rd_busy_o = busy_i[rd_addr_i];
        if (is_zero) begin
            rd_data_o = '0;
            rd_busy_o = 1'b0;
        end else if (hit) begin
            rd_data_o = wr_data_i;
            rd_busy_o = 1'b0;
        end
    end

endmodule

// File: rtl/reg_bank_sb.sv
// Architectural register file with a per-register busy scoreboard.
// Reads are combinational; writes, issue marks and flushes take effect on the rising edge.
module reg_bank_sb
    import reg_bank_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    reg_bank_sb_if.slave  bus
);

    localparam int AW = addr_width(NREGS);

    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           busy_q, busy_d;
    logic [NRD-1:0]             rd_busy;
    logic                       wr_en;

    // Forwarding must not leak write data onto the read ports while reset is held
    assign wr_en = bus.i_wr_en & i_rstn;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en && bus.i_wr_addr != '0) begin
            regs_d[bus.i_wr_addr] = bus.i_wr_data;
        end
        if (bus.i_wr_en) begin
            busy_d[bus.i_wr_addr] = 1'b0;
        end
        // A same-cycle issue is a newer producer, so it overrides the write's clear
        if (bus.i_iss_en && bus.i_iss_addr != '0) begin
            busy_d[bus.i_iss_addr] = 1'b1;
        end
        if (bus.i_flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        rb_read_port #(
            .XLEN   (XLEN),
            .NREGS  (NREGS),
            .BYPASS (BYPASS),
            .AW     (AW)
        ) u_port (
            .rd_addr_i (bus.i_rd_addr[p]),
            .regs_i    (regs_q),
            .busy_i    (busy_q),
            .wr_en_i   (wr_en),
            .wr_addr_i (bus.i_wr_addr),
            .wr_data_i (bus.i_wr_data),
            .rd_data_o (bus.o_rd_data[p]),
            .rd_busy_o (rd_busy[p])
        );
    end

    assign bus.o_rd_busy = rd_busy;
    assign bus.o_stall   = |rd_busy;

endmodule

// File: tb/tb_reg_bank_sb.sv
// Bench for reg_bank_sb: a forwarding and a non-forwarding instance share one stimulus stream,
// and a reference model predicts every cycle's read data, busy flags and stall.
module tb_reg_bank_sb;
    import reg_bank_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 3;
    localparam int AW    = 5;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    wb_t                    wb;
    logic                   iss_en;
    logic [AW-1:0]          iss_addr;
    logic                   flush;
    logic [NRD-1:0][AW-1:0] rd;

    reg_bank_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus1 ();
    reg_bank_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus0 ();

    assign bus1.i_rd_addr  = rd;
    assign bus1.i_wr_en    = wb.en;
    assign bus1.i_wr_addr  = wb.addr;
    assign bus1.i_wr_data  = wb.data;
    assign bus1.i_iss_en   = iss_en;
    assign bus1.i_iss_addr = iss_addr;
    assign bus1.i_flush    = flush;
    assign bus0.i_rd_addr  = rd;
    assign bus0.i_wr_en    = wb.en;
    assign bus0.i_wr_addr  = wb.addr;
    assign bus0.i_wr_data  = wb.data;
    assign bus0.i_iss_en   = iss_en;
    assign bus0.i_iss_addr = iss_addr;
    assign bus0.i_flush    = flush;

    reg_bank_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut1 (
        .i_clk (clk), .i_rstn (rstn), .bus (bus1.slave)
    );
    reg_bank_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut0 (
        .i_clk (clk), .i_rstn (rstn), .bus (bus0.slave)
    );

    // Reference state: register contents and pending-producer marks
    logic [31:0] mem [NREGS];
    bit          bsy [NREGS];

    typedef struct {
        string                  tag;
        logic [NRD-1:0][31:0]   d1, d0;
        logic [NRD-1:0]         b1, b0;
        logic                   s1, s0;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            for (int p = 0; p < NRD; p++) begin
                chk($sformatf("%s byp data[%0d]", e.tag, p), 64'(bus1.o_rd_data[p]), 64'(e.d1[p]));
                chk($sformatf("%s byp busy[%0d]", e.tag, p), 64'(bus1.o_rd_busy[p]), 64'(e.b1[p]));
                chk($sformatf("%s nobyp data[%0d]", e.tag, p), 64'(bus0.o_rd_data[p]), 64'(e.d0[p]));
                chk($sformatf("%s nobyp busy[%0d]", e.tag, p), 64'(bus0.o_rd_busy[p]), 64'(e.b0[p]));
            end
            chk($sformatf("%s byp stall", e.tag), 64'(bus1.o_stall), 64'(e.s1));
            chk($sformatf("%s nobyp stall", e.tag), 64'(bus0.o_stall), 64'(e.s0));
        end
    end

    task automatic clear_model();
        for (int r = 0; r < NREGS; r++) begin
            mem[r] = '0;
            bsy[r] = 1'b0;
        end
    endtask

    task automatic idle();
        wb       = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
    endtask

    // Predict this cycle's outputs, then advance the model across the next rising edge
    task automatic step(input string tag);
        exp_t e;
        int   a;
        if (!rstn) clear_model();
        e.tag = tag;
        for (int p = 0; p < NRD; p++) begin
            a = int'(rd[p]);
            if (a == 0) begin
                e.d1[p] = '0; e.d0[p] = '0; e.b1[p] = 1'b0; e.b0[p] = 1'b0;
            end else begin
                e.d0[p] = mem[a];
                e.b0[p] = bsy[a];
                if (rstn && wb.en && int'(wb.addr) == a) begin
                    e.d1[p] = wb.data;
                    e.b1[p] = 1'b0;
                end else begin
                    e.d1[p] = mem[a];
                    e.b1[p] = bsy[a];
                end
            end
        end
        e.s1 = |e.b1;
        e.s0 = |e.b0;
        q.push_back(e);
        @(posedge clk);
        if (rstn) begin
            if (wb.en && wb.addr != 0) mem[wb.addr] = wb.data;
            if (wb.en) bsy[wb.addr] = 1'b0;
            if (iss_en && iss_addr != 0) bsy[iss_addr] = 1'b1;
            if (flush) for (int r = 0; r < NREGS; r++) bsy[r] = 1'b0;
        end
        #1;
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2);
        rd[0] = AW'(a0);
        rd[1] = AW'(a1);
        rd[2] = AW'(a2);
    endtask

    initial begin
        idle();
        rd = '0;
        clear_model();
        @(posedge clk);
        #1;

        // Held in reset: write and issue are ignored, everything reads zero
        wb = '{en: 1'b1, addr: 5'd5, data: 32'hCAFE0005};
        iss_en = 1'b1; iss_addr = 5'd6; set_rd(5, 6, 0);
        step("rst_hold");
        idle();
        step("rst_hold2");
        rstn = 1'b1;

        for (int r = 0; r < NREGS; r++) begin
            set_rd(r, (r + 1) % NREGS, (r + 2) % NREGS);
            step($sformatf("post_rst r%0d", r));
        end

        wb = '{en: 1'b1, addr: 5'd5, data: 32'hDEADBEEF}; set_rd(0, 0, 0);
        step("wr r5");
        idle(); set_rd(5, 5, 5);
        step("rd r5");

        wb = '{en: 1'b1, addr: 5'd7, data: 32'hAAAA0007};
        step("wr r7 old");
        wb = '{en: 1'b1, addr: 5'd7, data: 32'h12345678}; set_rd(0, 7, 5);
        step("bypass r7");
        idle();
        step("after r7");

        iss_en = 1'b1; iss_addr = 5'd3; set_rd(3, 0, 1);
        step("iss r3");
        idle(); set_rd(3, 3, 2);
        step("busy r3");
        wb = '{en: 1'b1, addr: 5'd3, data: 32'h00000033};
        step("wr r3");
        idle();
        step("clr r3");
        wb = '{en: 1'b1, addr: 5'd3, data: 32'h00000333}; iss_en = 1'b1; iss_addr = 5'd3;
        step("iss+wr r3");
        idle();
        step("still busy r3");

        iss_en = 1'b1; iss_addr = 5'd9; set_rd(9, 10, 11);
        step("iss r9");
        iss_addr = 5'd10;
        step("iss r10");
        iss_addr = 5'd11; flush = 1'b1;
        step("flush+iss r11");
        idle();
        step("after flush");
        wb = '{en: 1'b1, addr: 5'd0, data: 32'h00000055}; set_rd(0, 0, 3);
        step("wr r0");
        idle();
        step("rd r0");

        wb = '{en: 1'b1, addr: 5'd4, data: 32'h44444444}; set_rd(4, 4, 3);
        step("wr r4");
        idle(); iss_en = 1'b1; iss_addr = 5'd4;
        step("iss r4");
        idle();
        rstn = 1'b0;
        step("async rst");
        step("rst held");
        rstn = 1'b1;
        step("after rst");

        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < NRD; p++) rd[p] = AW'($urandom_range(0, NREGS - 1));
            wb.en    = 1'($urandom_range(0, 1));
            wb.addr  = AW'($urandom_range(0, NREGS - 1));
            wb.data  = $urandom;
            if ($urandom_range(0, 3) == 0) wb.addr = rd[$urandom_range(0, NRD - 1)];
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = AW'($urandom_range(0, NREGS - 1));
            flush    = ($urandom_range(0, 15) == 0);
            rstn     = ($urandom_range(0, 63) != 0);
            step($sformatf("rand%0d", i));
        end
        rstn = 1'b1;
        idle();

        for (int k = 0; k < 4 && q.size() > 0; k++) @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
